// File: rtl/mont_modexp.sv
// Left-to-right square-and-multiply modular exponentiation controller that
// sequences Montgomery multiplications over an external multiplier port.
module mont_modexp #(
  parameter int WIDTH     = 512,
  parameter int EXP_WIDTH = 512,
  parameter int CNT_W     = 10
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  input  logic [WIDTH-1:0]     in_x,
  input  logic [EXP_WIDTH-1:0] in_e,
  input  logic [WIDTH-1:0]     in_m,
  input  logic [WIDTH-1:0]     in_r,
  input  logic [WIDTH-1:0]     in_r2,
  output logic [WIDTH-1:0]     result,
  output logic                 done,
  output logic                 busy,
  output logic                 mm_start,
  output logic [WIDTH-1:0]     mm_a,
  output logic [WIDTH-1:0]     mm_b,
  output logic [WIDTH-1:0]     mm_m,
  input  logic [WIDTH-1:0]     mm_result,
  input  logic                 mm_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONV,
    S_SQR,
    S_MUL,
    S_NEXT,
    S_OUT,
    S_FIN
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [WIDTH-1:0]     acc;
  logic [WIDTH-1:0]     xm;
  logic [WIDTH-1:0]     m_reg;
  logic [EXP_WIDTH-1:0] e_sh;
  logic [CNT_W-1:0]     bit_cnt;
  logic                 mul_ack;
  logic                 launch;
  logic [WIDTH-1:0]     op_a;
  logic [WIDTH-1:0]     op_b;

  function automatic logic is_mul(input state_t s);
    return (s == S_CONV) || (s == S_SQR) || (s == S_MUL) || (s == S_OUT);
  endfunction

  // A completion in the launch cycle belongs to no request of ours.
  assign mul_ack = mm_done && !mm_start;

  assign done = (state == S_FIN);
  assign busy = (state != S_IDLE);
  assign mm_m = m_reg;

  always_comb begin
    state_nxt = state;
    op_a      = '0;
    op_b      = '0;
    launch    = 1'b0;

    case (state)
      S_IDLE: if (start) state_nxt = S_CONV;
      S_CONV: if (mul_ack) state_nxt = S_SQR;
      S_SQR:  if (mul_ack) state_nxt = e_sh[EXP_WIDTH-1] ? S_MUL : S_NEXT;
      S_MUL:  if (mul_ack) state_nxt = S_NEXT;
      S_NEXT: state_nxt = (bit_cnt == '0) ? S_OUT : S_SQR;
      S_OUT:  if (mul_ack) state_nxt = S_FIN;
      S_FIN:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase

    launch = is_mul(state_nxt) && (state_nxt != state);

    // Operands are chosen for the state being entered; MUL follows SQR on the
    // same edge acc is rewritten, so it takes the product directly.
    case (state_nxt)
      S_CONV: begin
        op_a = in_x;
        op_b = in_r2;
      end
      S_SQR: begin
        op_a = acc;
        op_b = acc;
      end
      S_MUL: begin
        op_a = mm_result;
        op_b = xm;
      end
      S_OUT: begin
        op_a = acc;
        op_b = WIDTH'(1);
      end
      default: begin
        op_a = '0;
        op_b = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mm_start <= 1'b0;
      mm_a     <= '0;
      mm_b     <= '0;
      m_reg    <= '0;
      acc      <= '0;
      xm       <= '0;
      e_sh     <= '0;
      bit_cnt  <= '0;
      result   <= '0;
    end else begin
      mm_start <= launch;
      if (launch) begin
        mm_a <= op_a;
        mm_b <= op_b;
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            m_reg   <= in_m;
            acc     <= in_r;
            e_sh    <= in_e;
            bit_cnt <= CNT_W'(EXP_WIDTH - 1);
          end
        end
        S_CONV: if (mul_ack) xm <= mm_result;
        S_SQR, S_MUL: if (mul_ack) acc <= mm_result;
        S_NEXT: begin
          // The exponent is shifted so its MSB is always the bit under test.
          if (bit_cnt != '0) begin
            bit_cnt <= bit_cnt - CNT_W'(1);
            e_sh    <= e_sh << 1;
          end
        end
        S_OUT: if (mul_ack) result <= mm_result;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mont_modexp.md
Name: mont_modexp

Overview:
- Modular exponentiation controller that sits directly upstream of the `montgomery` multiplier. It computes `result = x^e mod M` by left-to-right square-and-multiply.
- It issues a sequence of Montgomery multiplications over an external multiplier port: the `montgomery` instance, or a behavioural model in the bench.
- Domain conversion uses host-supplied `R mod M` and `R^2 mod M`, with `R = 2^WIDTH`. This keeps all modular reduction inside the multiplier.

Parameters:
WIDTH, 512, operand/modulus width; must equal multiplier width
EXP_WIDTH, 512, exponent bits scanned (all bits, MSB first, no leading-zero skip)
CNT_W, 10, exponent bit counter width; must satisfy 2^CNT_W > EXP_WIDTH

Ports:
clk  in  1  clock, rising edge
resetn  in  1  asynchronous active-low reset
start  in  1  one-cycle request; sampled only in IDLE
in_x  in  WIDTH  base, < M
in_e  in  EXP_WIDTH  exponent
in_m  in  WIDTH  odd modulus
in_r  in  WIDTH  R mod M
in_r2  in  WIDTH  R^2 mod M
result  out  WIDTH  x^e mod M; valid from done pulse until next accepted start
done  out  1  one-cycle pulse when result is updated
busy  out  1  high from cycle after accepted start until done cycle inclusive
mm_start  out  1  one-cycle pulse launching a multiplication
mm_a  out  WIDTH  multiplier operand A; held stable from mm_start until mm_done
mm_b  out  WIDTH  multiplier operand B; held stable from mm_start until mm_done
mm_m  out  WIDTH  modulus; equals latched M
mm_result  in  WIDTH  multiplier product, valid when mm_done=1
mm_done  in  1  multiplier completion pulse

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE;
  - result, mm_a, mm_b, mm_m, all internal registers = 0;
  - done = busy = mm_start = 0.
  - A reset mid-operation aborts immediately; an outstanding multiplier result is ignored.
- IDLE, start=1: latch x, e, M, R, R2 into internal registers. Inputs may change afterwards.
  - Load `acc <= R`.
  - Load bit counter `i <= EXP_WIDTH-1`.
  - Go to CONV.
  - start while not IDLE is ignored (no queueing).
- Multiplication protocol, every state marked (mul):
  - First cycle in the state: drive mm_a/mm_b, pulse mm_start for exactly one cycle.
  - Then wait for mm_done=1. On that edge, capture mm_result into the target register and transition.
  - mm_done arriving in the same cycle as mm_start is ignored; the multiplier has at least 1 cycle latency.
- States:
  - CONV (mul): `a=x, b=R2`; `xm <= mm_result`; go to SQR.
  - SQR (mul): `a=acc, b=acc`; `acc <= mm_result`. If `e[i]=1` go to MUL; else go to NEXT.
  - MUL (mul): `a=acc, b=xm`; `acc <= mm_result`; go to NEXT.
  - NEXT (1 cycle, no mul): if `i==0` go to OUT; else `i <= i-1`, go to SQR.
  - OUT (mul): `a=acc, b=1`; `result <= mm_result`; go to FIN.
  - FIN (1 cycle): `done=1`, `busy=1`; go to IDLE.
- Multiplication count per operation: `2 + EXP_WIDTH + popcount(e)`. Latency is data-dependent only through popcount(e) and multiplier latency.
- e=0: no MUL steps are taken and the result is `R*1*R^-1 = 1` (M>1).
- result is only overwritten at OUT completion. It keeps the previous value while busy.
- mm_m is driven from latched M for the whole operation.
- M must be odd and > 1; behaviour for other M is undefined, with no detection.

Test Plan:
- Bench setup:
  - WIDTH=512, EXP_WIDTH=8.
  - Behavioural multiplier returns `a*b*R^-1 mod M` with 5-cycle latency.
  - A final run replaces the model with the real `montgomery` instance.
- Basic exponent: M=5, R=1, R2=1, x=3, e=0x0D -> result=3, done pulses once. Exactly 13 mm_start pulses, 8 SQR and 3 MUL.
- e=0: M=5, R=1, R2=1, x=3, e=0x00 -> result=1, 10 mm_start pulses, no MUL.
- All exponent bits set: M=7, R=4, R2=2, x=2, e=0xFF -> result=1, 18 mm_start pulses. Then x=3, e=0x05 -> result=5 (`3^5=243≡5`). The previous result stays 1 while busy.
- start while busy: assert start and change in_x mid-operation -> ignored; result still 3 for the first vector in the basic-exponent scenario.
- Reset mid-operation: drop resetn during the 3rd SQR -> all outputs 0 immediately. After release, a new start with the basic-exponent vector yields 3. A late mm_done from the model is ignored.
- Full width: EXP_WIDTH=512, random odd 512-bit M, random x and e with Python-generated R and R2 -> result equals `pow(x,e,M)` over 20 vectors. The mm_a/mm_b stability assertion holds throughout.
